// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: datapath widths, opcode map and
// the fetch-stage state encoding.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Last populated ROM address; the program counter wraps to zero after it.
  localparam logic [ADDR_W-1:0] PC_LAST = 8'd16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter for the fetch stage: increments with wrap at PC_LAST and
// accepts redirect targets, forcing out-of-range targets back to zero.
module program_counter #(
  parameter int                ADDR_W  = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] PC_LAST = cpu_pkg::PC_LAST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] load_target_s;

  // Sequential successor and clamped redirect target.
  always_comb begin
    pc_inc_s      = {ADDR_W{1'b0}};
    load_target_s = {ADDR_W{1'b0}};
    if (pc_r == PC_LAST) begin
      pc_inc_s = {ADDR_W{1'b0}};
    end else begin
      pc_inc_s = pc_r + ADDR_W'(1);
    end
    if (load_addr > PC_LAST) begin
      load_target_s = {ADDR_W{1'b0}};
    end else begin
      load_target_s = load_addr;
    end
  end

  // A redirect always wins over sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= {ADDR_W{1'b0}};
    end else if (load) begin
      pc_r <= load_target_s;
    end else if (inc) begin
      pc_r <= pc_inc_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the ROM address from the program counter,
// captures the asynchronous ROM word and hands it to decode over valid/ready.
module fetch_unit #(
  parameter int                ADDR_W     = cpu_pkg::ADDR_W,
  parameter int                DATA_W     = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] PC_LAST    = cpu_pkg::PC_LAST,
  parameter logic [3:0]        HLT_OPCODE = cpu_pkg::OP_HLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              halted,
  output logic [7:0]        fetch_count
);

  import cpu_pkg::*;

  fetch_state_t      state_r;
  logic              halted_r;
  logic [DATA_W-1:0] instr_r;
  logic [ADDR_W-1:0] instr_pc_r;
  logic              instr_valid_r;
  logic [7:0]        fetch_count_r;
  logic [ADDR_W-1:0] pc_s;
  logic              load_s;
  logic              is_hlt_s;

  program_counter #(
    .ADDR_W  (ADDR_W),
    .PC_LAST (PC_LAST)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .inc       (load_s),
    .load      (jmp_valid),
    .load_addr (jmp_addr),
    .pc        (pc_s)
  );

  // A load happens when running, the slot is free or draining, and no redirect.
  always_comb begin
    load_s   = 1'b0;
    is_hlt_s = 1'b0;
    if ((state_r == ST_RUN) && (!instr_valid_r || instr_ready) && !jmp_valid) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
    if (rom_data[DATA_W-1 -: 4] == HLT_OPCODE) begin
      is_hlt_s = 1'b1;
    end else begin
      is_hlt_s = 1'b0;
    end
  end

  // Fetch FSM; halted is registered alongside the state it mirrors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          halted_r <= 1'b0;
          if (start) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (load_s && is_hlt_s) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
          end
        end
        ST_HALT: begin
          if (jmp_valid) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
          end else begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  // Instruction register: a redirect flushes, a load refills, an accept drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r       <= {DATA_W{1'b0}};
      instr_pc_r    <= {ADDR_W{1'b0}};
      instr_valid_r <= 1'b0;
    end else if (jmp_valid) begin
      instr_valid_r <= 1'b0;
    end else if (load_s) begin
      instr_r       <= rom_data;
      instr_pc_r    <= pc_s;
      instr_valid_r <= 1'b1;
    end else if (instr_valid_r && instr_ready) begin
      instr_valid_r <= 1'b0;
    end else begin
      instr_valid_r <= instr_valid_r;
    end
  end

  // Saturating count of words loaded into the instruction register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_r <= 8'd0;
    end else if (load_s && (fetch_count_r != 8'd255)) begin
      fetch_count_r <= fetch_count_r + 8'd1;
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

  assign rom_addr    = pc_s;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;
  assign halted      = halted_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a spec-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       jmp_valid;
  logic [7:0] jmp_addr;
  logic       halted;
  logic [7:0] fetch_count;

  logic [7:0] rom [0:16];

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model state: 0 idle, 1 run, 2 halt
  int   m_state;
  int   m_pc;
  int   m_ipc;
  int   m_cnt;
  int   m_instr;
  bit   m_valid;
  logic m_ld;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jmp_valid   (jmp_valid),
    .jmp_addr    (jmp_addr),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = (rom_addr <= 8'd16) ? rom[rom_addr[4:0]] : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: decides from the spec rules what happens at each rising edge.
  assign m_ld = (m_state == 1) && (!m_valid || instr_ready) && !jmp_valid;

  always @(posedge clk) begin
    if (rst) begin
      m_state <= 0; m_pc <= 0; m_ipc <= 0; m_cnt <= 0; m_instr <= 0; m_valid <= 1'b0;
    end else if (jmp_valid) begin
      m_pc    <= (jmp_addr > 16) ? 0 : int'(jmp_addr);
      m_valid <= 1'b0;
      m_state <= (m_state == 0 && !start) ? 0 : 1;
    end else if (m_ld) begin
      m_instr <= rom[m_pc];
      m_ipc   <= m_pc;
      m_valid <= 1'b1;
      m_pc    <= (m_pc + 1) % 17;
      m_cnt   <= (m_cnt < 255) ? m_cnt + 1 : 255;
      if ((rom[m_pc] >> 4) == 15) m_state <= 2;
    end else begin
      if (instr_ready) m_valid <= 1'b0;
      if (m_state == 0 && start) m_state <= 1;
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rom_addr", rom_addr, m_pc);
      chk("m_valid", instr_valid, m_valid);
      chk("m_halted", halted, m_state == 2);
      chk("m_fetch_count", fetch_count, m_cnt);
      if (m_valid) begin
        chk("m_instr", instr, m_instr);
        chk("m_instr_pc", instr_pc, m_ipc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_instr(input string tag, input logic [7:0] i, input logic [7:0] ipc,
                              input logic [7:0] cnt);
    chk({tag, "_instr"}, instr, i);
    chk({tag, "_instr_pc"}, instr_pc, ipc);
    chk({tag, "_valid"}, instr_valid, 1'b1);
    chk({tag, "_count"}, fetch_count, cnt);
  endtask

  initial begin
    for (int i = 0; i < 17; i++) rom[i] = {4'((i + 1) % 15), 4'(i)};
    rst = 1'b1; start = 1'b0; instr_ready = 1'b1; jmp_valid = 1'b0; jmp_addr = 8'd0;
    tick();
    chk_en = 1'b1;
    chk("rst_addr", rom_addr, 8'd0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_count", fetch_count, 8'd0);
    chk("rst_halted", halted, 1'b0);

    // Streaming at one instruction per cycle
    rst = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("idle_to_run_noload", instr_valid, 1'b0);
    tick(); expect_instr("s0", 8'h10, 8'd0, 8'd1);
    tick(); expect_instr("s1", 8'h21, 8'd1, 8'd2);
    tick(); expect_instr("s2", 8'h32, 8'd2, 8'd3);

    // Stall with a full slot, then reset mid-transfer
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); expect_instr("stall", 8'h32, 8'd2, 8'd3);
      chk("stall_pc", rom_addr, 8'd3);
    end
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("mrst_instr", instr, 8'h00);
    chk("mrst_ipc", instr_pc, 8'h00);
    chk("mrst_valid", instr_valid, 1'b0);
    chk("mrst_addr", rom_addr, 8'd0);
    chk("mrst_count", fetch_count, 8'd0);
    repeat (2) tick();
    chk("idle_nofetch", instr_valid, 1'b0);

    // Jump alone in IDLE stays IDLE; start+jump enters RUN at target
    jmp_valid = 1'b1; jmp_addr = 8'd7;
    tick(); jmp_valid = 1'b0;
    chk("idle_jmp_addr", rom_addr, 8'd7);
    tick();
    chk("idle_jmp_nofetch", instr_valid, 1'b0);
    jmp_valid = 1'b1; jmp_addr = 8'd0; start = 1'b1;
    tick(); jmp_valid = 1'b0; start = 1'b0;
    chk("start_jmp_addr", rom_addr, 8'd0);

    // Backpressure right after the first load
    tick(); expect_instr("bp0", 8'h10, 8'd0, 8'd1);
    for (int k = 0; k < 3; k++) begin
      tick(); expect_instr("bp_hold", 8'h10, 8'd0, 8'd1);
      chk("bp_pc", rom_addr, 8'd1);
    end
    instr_ready = 1'b1;
    tick(); expect_instr("bp_rel", 8'h21, 8'd1, 8'd2);

    // Wrap from PC_LAST to zero
    repeat (15) tick();
    chk("wrap_ipc16", instr_pc, 8'd16);
    chk("wrap_addr0", rom_addr, 8'd0);
    tick();
    chk("wrap_ipc0", instr_pc, 8'd0);
    chk("wrap_count", fetch_count, 8'd18);

    // Jump flushes the slot while a transfer is accepted
    jmp_valid = 1'b1; jmp_addr = 8'd5;
    tick(); jmp_valid = 1'b0;
    chk("jmp_flush", instr_valid, 1'b0);
    chk("jmp_addr5", rom_addr, 8'd5);
    chk("jmp_count", fetch_count, 8'd18);
    tick(); expect_instr("jmp_tgt", 8'h65, 8'd5, 8'd19);

    // Out-of-range target clamps to zero
    jmp_valid = 1'b1; jmp_addr = 8'd200;
    tick(); jmp_valid = 1'b0;
    chk("clamp_addr", rom_addr, 8'd0);
    rom[3] = 8'hF0;

    // HLT at address 3
    repeat (4) tick();
    expect_instr("hlt", 8'hF0, 8'd3, 8'd23);
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_pc_inc", rom_addr, 8'd4);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    chk("halt_drained", instr_valid, 1'b0);
    chk("halt_count", fetch_count, 8'd23);
    chk("halt_stays", halted, 1'b1);
    chk("halt_pc", rom_addr, 8'd4);
    jmp_valid = 1'b1; jmp_addr = 8'd0;
    tick(); jmp_valid = 1'b0;
    chk("resume_halted", halted, 1'b0);
    chk("resume_addr", rom_addr, 8'd0);
    tick(); expect_instr("resume", 8'h10, 8'd0, 8'd24);
    rom[3] = 8'h43;

    // Counter saturation
    repeat (240) tick();
    chk("sat_count", fetch_count, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the 8-bit CPU, directly upstream of the instruction decoder and driving the ROM's address port. Holds the program counter and presents it combinationally on rom_addr. The ROM read is asynchronous, so fetch_unit captures rom_data in the same cycle into an instruction register. It hands the instruction to decode over a valid/ready handshake and supports jumps, HLT detection and a fetch counter.

Parameters:
ADDR_W, 8, program counter / ROM address width
DATA_W, 8, instruction width (opcode = [7:4], operand = [3:0])
PC_LAST, 8'd16, last valid ROM address; PC wraps to 0 after it (ROM depth 17)
HLT_OPCODE, 4'hF, opcode that halts fetching

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  pulse/level: leave IDLE and begin fetching
rom_addr  output  ADDR_W  ROM address, equals pc register (combinational from register)
rom_data  input  DATA_W  ROM read data, valid same cycle as rom_addr
instr  output  DATA_W  registered instruction to decoder
instr_pc  output  ADDR_W  address instr was fetched from
instr_valid  output  1  instr holds an unconsumed instruction
instr_ready  input  1  decoder accepts instr this cycle
jmp_valid  input  1  redirect request from execute
jmp_addr  input  ADDR_W  redirect target
halted  output  1  HALT state indicator
fetch_count  output  8  instructions loaded into instr since reset, saturating at 255

Behaviour:
- Reset (rst=1 at clock edge, any state, mid-transfer included): pc=0, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0, state=IDLE. rst has priority over all inputs.
- States: IDLE, RUN, HALT.
  - IDLE: no fetch. start=1 -> RUN next cycle.
  - RUN: fetches when load = (!instr_valid || instr_ready) && !jmp_valid.
  - HALT: no fetch. halted=1. Exits only on rst, or on jmp_valid (-> RUN).
- Load cycle:
  - instr <= rom_data; instr_pc <= pc; instr_valid <= 1.
  - pc <= (pc == PC_LAST) ? 0 : pc+1.
  - fetch_count <= fetch_count+1 unless already 255.
- If the loaded word's rom_data[7:4] == HLT_OPCODE:
  - State -> HALT on the same edge.
  - The HLT instruction is still presented with instr_valid=1.
  - pc still increments.
- Not-loading with instr_ready=1 and instr_valid=1 clears instr_valid (transfer done, slot empty).
- Not-loading with instr_ready=0 holds instr, instr_pc and instr_valid stable.
- Throughput: 1 instruction/cycle while instr_ready=1. Latency from pc change to instr_valid is 1 cycle.
- instr_ready while instr_valid=0 is ignored.
- jmp_valid=1 (any state):
  - Target: pc <= (jmp_addr > PC_LAST) ? 0 : jmp_addr.
  - Flush: instr_valid <= 0. No load that cycle. fetch_count unchanged.
  - If instr_valid and instr_ready are both 1 in that cycle, the transfer counts as accepted by decode; the register is still cleared.
  - State transitions on jump: IDLE stays IDLE; RUN stays RUN; HALT -> RUN.
- Simultaneous start and jmp_valid in IDLE: pc loads the jump target and state -> RUN.
- start is ignored in RUN and HALT.
- fetch_count does not wrap.
- halted is registered: 1 exactly when state == HALT.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W and DATA_W constants.
  - Opcode constants, including OP_HLT = 4'hF.
  - Fetch state typedef/encoding: IDLE=2'd0, RUN=2'd1, HALT=2'd2.
- One natural sub-module, program_counter:
  - Inputs: clk, rst, inc, load, load_addr.
  - Handles wrap at PC_LAST and clamping of out-of-range load targets.
- FSM, instruction register and counter stay in fetch_unit.

Test Plan:
- Reset then start=1, ROM = 0x10,0x21,0x32,..., instr_ready=1 -> instr sequence 0x10,0x21,0x32 on consecutive cycles; instr_pc 0,1,2; fetch_count 1,2,3.
- Backpressure: instr_ready=0 for 3 cycles after first load -> instr=0x10, instr_pc=0 held, pc stays 1, fetch_count stays 1; release -> 0x21 on next edge.
- Wrap, with no HLT in ROM and ready=1: after instr_pc=16 the next instr_pc=0 and rom_addr=0.
- Jump, HLT and clamp:
  - jmp_valid with jmp_addr=5 while instr_valid=1 -> next cycle instr_valid=0, rom_addr=5; following cycle instr_pc=5.
  - jmp_addr=200 -> rom_addr=0.
- HLT: ROM[3]=0xF0 -> instr=0xF0 presented with instr_valid=1, halted=1 after that edge, no further loads, fetch_count frozen.
  - A subsequent jmp_valid with jmp_addr=0 -> halted=0 and fetching resumes at 0.
- Mid-run reset: rst=1 for one cycle while instr_valid=1 and ready=0 -> all outputs 0, state IDLE; no fetch until start=1.
